// File: rtl/pvr_interp_seq.sv
// Plane-equation interpolator sequencer: time-shares setup and divider across
// attributes, then issues one span request per row per attribute for a tile.
module pvr_interp_seq #(
    parameter int NUM_ATTR  = 4,
    parameter int SETUP_LAT = 2,
    parameter int ROWS      = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tri_valid,
    output logic        tri_ready,
    input  logic [4:0]  tile_x,
    input  logic [4:0]  tile_y,
    output logic [2:0]  attr_sel,
    output logic        setup,
    output logic        div_start,
    input  logic        div_done,
    output logic        coef_we,
    output logic        span_valid,
    input  logic        span_ready,
    output logic [11:0] x_ps,
    output logic [11:0] y_ps,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WAIT, S_DIVS, S_DIVW, S_LATCH, S_RASTER, S_DONE
    } state_t;

    localparam logic [2:0] LAST_ATTR = 3'(NUM_ATTR - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [3:0] WAIT_LAST = 4'(SETUP_LAT - 1);

    state_t     state, state_n;
    logic [2:0] attr_n;
    logic [4:0] row_q, row_n;
    logic [3:0] wait_q, wait_n;
    logic [4:0] tile_x_q, tile_y_q;

    always_comb begin
        state_n = state;
        attr_n  = attr_sel;
        row_n   = row_q;
        wait_n  = wait_q;
        case (state)
            S_IDLE: begin
                if (tri_valid) begin
                    state_n = S_SETUP;
                    attr_n  = '0;
                end
            end
            S_SETUP: begin
                state_n = S_WAIT;
                wait_n  = '0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) state_n = S_DIVS;
                else                     wait_n  = wait_q + 4'd1;
            end
            S_DIVS: state_n = S_DIVW;
            S_DIVW: begin
                if (div_done) state_n = S_LATCH;
            end
            S_LATCH: begin
                if (attr_sel == LAST_ATTR) begin
                    attr_n  = '0;
                    row_n   = '0;
                    state_n = S_RASTER;
                end else begin
                    attr_n  = attr_sel + 3'd1;
                    state_n = S_SETUP;
                end
            end
            S_RASTER: begin
                // Attribute is the inner loop; row advances when it wraps.
                if (span_ready) begin
                    if (attr_sel == LAST_ATTR) begin
                        attr_n = '0;
                        if (row_q == LAST_ROW) begin
                            row_n   = '0;
                            state_n = S_DONE;
                        end else begin
                            row_n = row_q + 5'd1;
                        end
                    end else begin
                        attr_n = attr_sel + 3'd1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with
    // the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            row_q      <= '0;
            wait_q     <= '0;
            tile_x_q   <= '0;
            tile_y_q   <= '0;
            attr_sel   <= '0;
            tri_ready  <= 1'b1;
            busy       <= 1'b0;
            setup      <= 1'b0;
            div_start  <= 1'b0;
            coef_we    <= 1'b0;
            span_valid <= 1'b0;
            done       <= 1'b0;
            x_ps       <= '0;
            y_ps       <= '0;
        end else begin
            state    <= state_n;
            row_q    <= row_n;
            wait_q   <= wait_n;
            attr_sel <= attr_n;
            if (state == S_IDLE && tri_valid) begin
                tile_x_q <= tile_x;
                tile_y_q <= tile_y;
            end
            tri_ready  <= (state_n == S_IDLE);
            busy       <= (state_n != S_IDLE);
            setup      <= (state_n == S_SETUP);
            div_start  <= (state_n == S_DIVS);
            coef_we    <= (state_n == S_LATCH);
            span_valid <= (state_n == S_RASTER);
            done       <= (state_n == S_DONE);
            if (state_n == S_RASTER) begin
                x_ps <= {2'b00, tile_x_q, 5'd0};
                y_ps <= {2'b00, tile_y_q, row_n};
            end
        end
    end

endmodule

// File: tb/tb_pvr_interp_seq.sv
// Directed bench for pvr_interp_seq: default config plus a 1-attribute,
// 1-row instance, with hand-computed cycle-exact expectations.
module tb_pvr_interp_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tri_valid = 1'b0, div_done = 1'b0, span_ready = 1'b0;
    logic [4:0]  tile_x = '0, tile_y = '0;
    logic        tri_ready, setup, div_start, coef_we, span_valid, busy, done;
    logic [2:0]  attr_sel;
    logic [11:0] x_ps, y_ps;

    logic        tri_valid_b = 1'b0, div_done_b = 1'b0, span_ready_b = 1'b0;
    logic [4:0]  tile_x_b = '0, tile_y_b = '0;
    logic        tri_ready_b, setup_b, div_start_b, coef_we_b, span_valid_b, busy_b, done_b;
    logic [2:0]  attr_sel_b;
    logic [11:0] x_ps_b, y_ps_b;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pvr_interp_seq #(.NUM_ATTR(4), .SETUP_LAT(2), .ROWS(32)) dut (
        .clock(clock), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tile_x(tile_x), .tile_y(tile_y), .attr_sel(attr_sel), .setup(setup),
        .div_start(div_start), .div_done(div_done), .coef_we(coef_we),
        .span_valid(span_valid), .span_ready(span_ready), .x_ps(x_ps), .y_ps(y_ps),
        .busy(busy), .done(done)
    );

    pvr_interp_seq #(.NUM_ATTR(1), .SETUP_LAT(2), .ROWS(1)) dut_min (
        .clock(clock), .reset(reset), .tri_valid(tri_valid_b), .tri_ready(tri_ready_b),
        .tile_x(tile_x_b), .tile_y(tile_y_b), .attr_sel(attr_sel_b), .setup(setup_b),
        .div_start(div_start_b), .div_done(div_done_b), .coef_we(coef_we_b),
        .span_valid(span_valid_b), .span_ready(span_ready_b), .x_ps(x_ps_b), .y_ps(y_ps_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept at c=0, tile (3,5), no stalls: setups 1,7,13,19; coef 6..24;
    // spans 25..152; done 153.
    task automatic run_nominal(input string tag);
        for (int c = 0; c <= 155; c++) begin
            @(negedge clock);
            tri_valid  = (c == 0);
            tile_x     = 5'd3;
            tile_y     = 5'd5;
            div_done   = 1'b1;
            span_ready = 1'b1;
            chk({tag, "_setup"}, setup, (c >= 1 && c <= 19 && (c - 1) % 6 == 0));
            chk({tag, "_divs"}, div_start, (c >= 4 && c <= 22 && (c - 4) % 6 == 0));
            chk({tag, "_coef"}, coef_we, (c >= 6 && c <= 24 && (c - 6) % 6 == 0));
            chk({tag, "_sv"}, span_valid, (c >= 25 && c <= 152));
            chk({tag, "_done"}, done, (c == 153));
            chk({tag, "_rdy"}, tri_ready, (c == 0 || c >= 154));
            if (c >= 6 && c <= 24 && (c - 6) % 6 == 0)
                chk({tag, "_coef_attr"}, attr_sel, (c - 6) / 6);
            if (c >= 25 && c <= 152) begin
                chk({tag, "_x"}, x_ps, 96);
                chk({tag, "_y"}, y_ps, 160 + (c - 25) / 4);
                chk({tag, "_attr"}, attr_sel, (c - 25) % 4);
            end
        end
    endtask

    initial begin
        int k;
        int done_at;
        logic pend;
        logic saw_done;

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_rdy", tri_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_setup", setup, 0);
        chk("rst_divs", div_start, 0);
        chk("rst_coef", coef_we, 0);
        chk("rst_sv", span_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_attr", attr_sel, 0);
        chk("rst_x", x_ps, 0);
        chk("rst_y", y_ps, 0);
        reset = 1'b0;

        run_nominal("nom");

        // Divider stall on attr 1: div_done low 10..20 (DIVW 11..21), high in WAIT.
        done_at = -1;
        for (int c = 0; c <= 165; c++) begin
            @(negedge clock);
            tri_valid  = (c == 0);
            div_done   = !(c >= 10 && c <= 20);
            span_ready = 1'b1;
            if (c <= 40) begin
                chk("stall_coef", coef_we, (c == 6 || c == 22 || c == 28 || c == 34));
                chk("stall_divs", div_start, (c == 4 || c == 10 || c == 26 || c == 32));
            end
            if (c == 22) chk("stall_coef_attr", attr_sel, 1);
            if (done) done_at = c;
        end
        chk("stall_done_at", done_at, 163);

        // Backpressure: random span_ready, 128 in-order spans for tile (7,2).
        k = 0;
        pend = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 2000 && !saw_done; c++) begin
            @(negedge clock);
            tri_valid = (c == 0);
            tile_x    = 5'd7;
            tile_y    = 5'd2;
            div_done  = 1'b1;
            if (pend) chk("bp_hold_valid", span_valid, 1);
            if (span_valid) begin
                if (k < 128) begin
                    chk("bp_x", x_ps, 224);
                    chk("bp_y", y_ps, 64 + k / 4);
                    chk("bp_attr", attr_sel, k % 4);
                end else begin
                    chk("bp_extra", k, 127);
                end
            end
            span_ready = 1'($urandom_range(0, 1));
            if (span_valid && span_ready) k++;
            pend = span_valid && !span_ready;
            if (done) saw_done = 1'b1;
        end
        chk("bp_saw_done", saw_done, 1);
        chk("bp_count", k, 128);

        // Reset during span 40 (cycle 65).
        for (int c = 0; c <= 65; c++) begin
            @(negedge clock);
            tri_valid  = (c == 0);
            tile_x     = 5'd3;
            tile_y     = 5'd5;
            div_done   = 1'b1;
            span_ready = 1'b1;
            if (c == 65) begin
                chk("rm_sv_pre", span_valid, 1);
                chk("rm_y_pre", y_ps, 170);
                chk("rm_attr_pre", attr_sel, 0);
                reset = 1'b1;
            end
        end
        @(negedge clock);
        chk("rm_sv", span_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_rdy", tri_ready, 1);
        chk("rm_done", done, 0);
        chk("rm_x", x_ps, 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("rm_no_done", done, 0);
            chk("rm_idle", busy, 0);
        end
        run_nominal("rm2");

        // tri_valid held high across two triangles; tile changes after first accept.
        for (int c = 0; c <= 310; c++) begin
            @(negedge clock);
            tri_valid  = (c <= 154);
            tile_x     = (c == 0) ? 5'd1 : (c <= 154) ? 5'd9 : 5'd0;
            tile_y     = (c == 0) ? 5'd2 : (c <= 154) ? 5'd4 : 5'd0;
            div_done   = 1'b1;
            span_ready = 1'b1;
            chk("br_rdy", tri_ready, (c == 0 || c == 154 || c >= 308));
            chk("br_done", done, (c == 153 || c == 307));
            if (c == 1 || c == 154 || c == 155) chk("br_setup", setup, (c != 154));
            if (c == 25) begin
                chk("br_x1", x_ps, 32);
                chk("br_y1", y_ps, 64);
            end
            if (c == 179) begin
                chk("br_x2", x_ps, 288);
                chk("br_y2", y_ps, 128);
                chk("br_attr2", attr_sel, 0);
            end
        end

        // Minimum config: NUM_ATTR=1, ROWS=1, tile (31,31).
        for (int c = 0; c <= 10; c++) begin
            @(negedge clock);
            tri_valid_b  = (c == 0);
            tile_x_b     = 5'd31;
            tile_y_b     = 5'd31;
            div_done_b   = 1'b1;
            span_ready_b = 1'b1;
            chk("min_setup", setup_b, (c == 1));
            chk("min_coef", coef_we_b, (c == 6));
            chk("min_sv", span_valid_b, (c == 7));
            chk("min_done", done_b, (c == 8));
            chk("min_rdy", tri_ready_b, (c == 0 || c >= 9));
            if (c == 7) begin
                chk("min_x", x_ps_b, 992);
                chk("min_y", y_ps_b, 992);
                chk("min_attr", attr_sel_b, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
